// File: rtl/mod_multicycle_control.sv
// mod_multicycle_control
//   Control unit for a multicycle MIPS datapath with a shared instruction/data
//   memory. A Moore FSM steps each instruction through fetch, decode, execute,
//   memory and writeback. The only input-qualified outputs are ir_write and
//   pc_write in FETCH, which fire on the cycle memory returns the instruction.
//   Supported: R-type, lw, sw, beq, j, jal, addi. Any other opcode traps.
//   A memory wait that runs past MEM_TIMEOUT cycles also traps.
//
// Ports
//   clk, reset_n    : rising-edge clock, asynchronous active-low reset
//   opcode          : IR[31:26], valid from DECODE onward
//   mem_ready       : memory completes the current access this cycle
//   pc_write        : unconditional PC load
//   pc_write_cond   : PC load gated by ALU zero (beq)
//   i_or_d          : memory address select (0 PC, 1 ALUOut)
//   mem_read        : memory read request
//   mem_write       : memory write request
//   ir_write        : instruction register load
//   mem_to_reg      : writeback select (00 ALUOut, 01 MDR, 10 PC)
//   reg_dst         : destination register (00 rt, 01 rd, 10 r31)
//   reg_write       : register file write enable
//   alu_src_a       : ALU A (0 PC, 1 rs)
//   alu_src_b       : ALU B (00 rt, 01 4, 10 imm, 11 imm<<2)
//   alu_op          : 0 add, 1 sub, 2 decode from funct
//   pc_source       : PC source (00 ALU, 01 ALUOut, 10 jump, 11 exception)
//   illegal_op      : one-cycle trap pulse
//   instr_count     : retired-instruction count, wraps
module mod_multicycle_control #(
  parameter int OPCODE_WIDTH = 6,
  parameter int ALU_OP_WIDTH = 3,
  parameter int CNT_WIDTH    = 16,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    mem_ready,
  output logic                    pc_write,
  output logic                    pc_write_cond,
  output logic                    i_or_d,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    ir_write,
  output logic [1:0]              mem_to_reg,
  output logic [1:0]              reg_dst,
  output logic                    reg_write,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic [1:0]              pc_source,
  output logic                    illegal_op,
  output logic [CNT_WIDTH-1:0]    instr_count
);

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'h00);
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'h02);
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL   = OPCODE_WIDTH'(6'h03);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'h04);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'h08);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'h23);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'h2B);

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD   = '0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB   = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_FUNCT = ALU_OP_WIDTH'(2);

  // Wide enough to hold MEM_TIMEOUT; the counter saturates so a disabled
  // timeout never wraps back into a false match.
  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EX     = 4'd7,
    S_R_WB     = 4'd8,
    S_BEQ      = 4'd9,
    S_JMP      = 4'd10,
    S_JAL      = 4'd11,
    S_ADDI_EX  = 4'd12,
    S_ADDI_WB  = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  state_t                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   timed_out;
  logic                   retire;

  always_comb begin
    state_d   = state_q;
    timed_out = (MEM_TIMEOUT != 0) && (wait_q == TIMEOUT_V);
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      // mem_ready is tested before the timeout so a late ready still wins.
      S_FETCH: begin
        if (mem_ready)      state_d = S_DECODE;
        else if (timed_out) state_d = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_R_EX;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JMP;
          OP_JAL:       state_d = S_JAL;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)      state_d = S_MEM_WB;
        else if (timed_out) state_d = S_TRAP;
      end
      S_MEM_WR: begin
        if (mem_ready)      state_d = S_FETCH;
        else if (timed_out) state_d = S_TRAP;
      end
      S_R_EX:     state_d = S_R_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BEQ, S_JMP, S_JAL, S_TRAP:
                  state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase

    // Any state change clears the counter, which covers entry to the three
    // waiting states; non-waiting states change every cycle anyway.
    wait_d = wait_q;
    if ((state_d != state_q) || mem_ready) wait_d = '0;
    else if (wait_q != '1)                 wait_d = wait_q + WAIT_W'(1);

    retire = (state_d == S_FETCH) &&
             (state_q inside {S_MEM_WR, S_MEM_WB, S_R_WB, S_ADDI_WB,
                              S_BEQ, S_JMP, S_JAL});
    cnt_d  = retire ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_count = cnt_q;

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 2'b00;
    reg_dst       = 2'b00;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC+4 are captured only on the cycle the instruction arrives.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEM_ADDR, S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      S_ADDI_WB:  reg_write = 1'b1;
      S_R_EX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      // r31 receives PC+4, already latched into the PC during FETCH.
      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
      end
      S_TRAP: begin
        illegal_op = 1'b1;
        pc_write   = 1'b1;
        pc_source  = 2'b11;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mod_multicycle_control.sv
// tb_mod_multicycle_control
//   Bench for mod_multicycle_control. Instructions are described by opcode and
//   memory stall lengths; the bench expands each into the per-cycle control
//   words the instruction must produce and tracks the retired count itself.
//   A narrow counter width makes the wrap observable in a short run.
module tb_mod_multicycle_control;

  localparam int CNT_W = 4;
  localparam int TMO   = 15;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic             ir_write, reg_write, alu_src_a, illegal_op;
  logic [1:0]       mem_to_reg, reg_dst, alu_src_b, pc_source;
  logic [2:0]       alu_op;
  logic [CNT_W-1:0] instr_count;

  mod_multicycle_control #(
    .OPCODE_WIDTH(6), .ALU_OP_WIDTH(3), .CNT_WIDTH(CNT_W), .MEM_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, illegal_op};

  int          checks = 0;
  int          errors = 0;
  logic [CNT_W-1:0] exp_cnt;

  logic [19:0] V_IDLE, V_FW, V_FG, V_DEC, V_ADDR, V_MRD, V_MWR, V_MWB, V_AWB;
  logic [19:0] V_REX, V_RWB, V_BEQ, V_JMP, V_JAL, V_TRAP;

  function automatic logic [19:0] mk(
    input logic pcw, input logic pcwc, input logic iord, input logic mr,
    input logic mw, input logic irw, input logic [1:0] m2r,
    input logic [1:0] rdst, input logic rw, input logic asa,
    input logic [1:0] asb, input logic [2:0] aop, input logic [1:0] psrc,
    input logic ill);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill};
  endfunction

  task automatic chk(input logic [19:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s ctl observed=%05h expected=%05h", tag, obs, exp);
    end
    checks++;
    assert (instr_count === exp_cnt) else begin
      errors++;
      $error("FAIL %s instr_count observed=%0d expected=%0d", tag, instr_count, exp_cnt);
    end
  endtask

  // One clock cycle: drive mem_ready in the low phase, then check.
  task automatic cyc(input logic [19:0] exp, input logic mr, input string tag);
    @(negedge clk);
    mem_ready = mr;
    #1;
    chk(exp, tag);
  endtask

  // A memory wait: stalls beyond TMO end in a trap after TMO+1 low cycles.
  task automatic wait_mem(input logic [19:0] vw, input logic [19:0] vg,
                          input int stall, input string tag, output bit trapped);
    trapped = 1'b0;
    if (stall > TMO) begin
      for (int i = 0; i <= TMO; i++) cyc(vw, 1'b0, tag);
      trapped = 1'b1;
    end else begin
      for (int i = 0; i < stall; i++) cyc(vw, 1'b0, tag);
      cyc(vg, 1'b1, tag);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int fs, input int ms);
    bit tr;
    opcode = op;
    wait_mem(V_FW, V_FG, fs, "fetch", tr);
    if (tr) begin
      cyc(V_TRAP, 1'($urandom_range(0, 1)), "trap_fetch_timeout");
      return;
    end
    cyc(V_DEC, 1'($urandom_range(0, 1)), "decode");
    case (op)
      6'h00: begin
        cyc(V_REX, 1'($urandom_range(0, 1)), "r_ex");
        cyc(V_RWB, 1'($urandom_range(0, 1)), "r_wb");
      end
      6'h23: begin
        cyc(V_ADDR, 1'($urandom_range(0, 1)), "lw_addr");
        wait_mem(V_MRD, V_MRD, ms, "mem_rd", tr);
        if (tr) begin
          cyc(V_TRAP, 1'($urandom_range(0, 1)), "trap_rd_timeout");
          return;
        end
        cyc(V_MWB, 1'($urandom_range(0, 1)), "mem_wb");
      end
      6'h2B: begin
        cyc(V_ADDR, 1'($urandom_range(0, 1)), "sw_addr");
        wait_mem(V_MWR, V_MWR, ms, "mem_wr", tr);
        if (tr) begin
          cyc(V_TRAP, 1'($urandom_range(0, 1)), "trap_wr_timeout");
          return;
        end
      end
      6'h04: cyc(V_BEQ, 1'($urandom_range(0, 1)), "beq");
      6'h02: cyc(V_JMP, 1'($urandom_range(0, 1)), "jmp");
      6'h03: cyc(V_JAL, 1'($urandom_range(0, 1)), "jal");
      6'h08: begin
        cyc(V_ADDR, 1'($urandom_range(0, 1)), "addi_ex");
        cyc(V_AWB, 1'($urandom_range(0, 1)), "addi_wb");
      end
      default: begin
        cyc(V_TRAP, 1'($urandom_range(0, 1)), "trap_illegal");
        return;
      end
    endcase
    exp_cnt = exp_cnt + 1'b1;
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] o;
    case ($urandom_range(0, 7))
      0: o = 6'h00;
      1: o = 6'h23;
      2: o = 6'h2B;
      3: o = 6'h04;
      4: o = 6'h02;
      5: o = 6'h03;
      6: o = 6'h08;
      default: begin
        o = 6'($urandom_range(0, 63));
        while (o inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h08})
          o = 6'($urandom_range(0, 63));
      end
    endcase
    return o;
  endfunction

  function automatic int pick_stall();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(TMO - 1, TMO + 1));
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    V_IDLE = '0;
    V_FW   = mk(0,0,0,1,0,0,2'b00,2'b00,0,0,2'b01,3'b000,2'b00,0);
    V_FG   = mk(1,0,0,1,0,1,2'b00,2'b00,0,0,2'b01,3'b000,2'b00,0);
    V_DEC  = mk(0,0,0,0,0,0,2'b00,2'b00,0,0,2'b11,3'b000,2'b00,0);
    V_ADDR = mk(0,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,3'b000,2'b00,0);
    V_MRD  = mk(0,0,1,1,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00,0);
    V_MWR  = mk(0,0,1,0,1,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00,0);
    V_MWB  = mk(0,0,0,0,0,0,2'b01,2'b00,1,0,2'b00,3'b000,2'b00,0);
    V_AWB  = mk(0,0,0,0,0,0,2'b00,2'b00,1,0,2'b00,3'b000,2'b00,0);
    V_REX  = mk(0,0,0,0,0,0,2'b00,2'b00,0,1,2'b00,3'b010,2'b00,0);
    V_RWB  = mk(0,0,0,0,0,0,2'b00,2'b01,1,0,2'b00,3'b000,2'b00,0);
    V_BEQ  = mk(0,1,0,0,0,0,2'b00,2'b00,0,1,2'b00,3'b001,2'b01,0);
    V_JMP  = mk(1,0,0,0,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b10,0);
    V_JAL  = mk(1,0,0,0,0,0,2'b10,2'b10,1,0,2'b00,3'b000,2'b10,0);
    V_TRAP = mk(1,0,0,0,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b11,1);

    reset_n   = 1'b0;
    opcode    = 6'h00;
    mem_ready = 1'b0;
    exp_cnt   = '0;
    #2;
    chk(V_IDLE, "reset_state");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk(V_IDLE, "idle_after_reset");

    // Directed instructions.
    run_instr(6'h23, 3, 3);
    run_instr(6'h00, 0, 0);
    run_instr(6'h2B, 0, 0);
    run_instr(6'h04, 0, 0);
    run_instr(6'h03, 0, 0);
    run_instr(6'h02, 0, 0);
    run_instr(6'h08, 0, 0);
    run_instr(6'h3F, 0, 0);
    run_instr(6'h00, TMO + 1, 0);
    run_instr(6'h00, TMO, 0);
    run_instr(6'h23, 0, TMO + 1);
    run_instr(6'h2B, 0, TMO);
    run_instr(6'h23, 0, TMO);

    // Random instruction stream; the retired count wraps along the way.
    for (int n = 0; n < 60; n++) run_instr(pick_op(), pick_stall(), pick_stall());

    // Asynchronous reset in the middle of a lw memory read.
    if (exp_cnt == '0) run_instr(6'h04, 0, 0);
    opcode = 6'h23;
    cyc(V_FG, 1'b1, "rst_fetch");
    cyc(V_DEC, 1'b0, "rst_decode");
    cyc(V_ADDR, 1'b0, "rst_addr");
    cyc(V_MRD, 1'b0, "rst_mem_rd");
    @(negedge clk);
    mem_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    exp_cnt = '0;
    chk(V_IDLE, "async_reset_mid_mem_rd");
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk(V_IDLE, "reset_held");
    reset_n = 1'b1;
    #1;
    chk(V_IDLE, "idle_after_release");
    run_instr(6'h08, 0, 0);
    run_instr(6'h00, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
